// File: rtl/ulm_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ulm_uart_pkg : shared FSM state encoding and UART defaults          |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
package ulm_uart_pkg;

    localparam int c_default_clks_per_bit = 104;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t c_st_idle   = 3'd0;
    localparam uart_state_t c_st_start  = 3'd1;
    localparam uart_state_t c_st_data   = 3'd2;
    localparam uart_state_t c_st_stop   = 3'd3;
    localparam uart_state_t c_st_finish = 3'd4;

    // True while a serial frame (start, data or stop bit) is on the line.
    function automatic logic is_frame_state(input uart_state_t s);
        return (s == c_st_start) || (s == c_st_data) || (s == c_st_stop);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_uart_tx_if : request, BRAM read port and UART status bundle    |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
interface bram_uart_tx_if #(
    parameter int ADDRW = 9
);
    logic             start_in;
    logic [ADDRW-1:0] base_in;
    logic [ADDRW:0]   len_in;
    logic [ADDRW-1:0] rd_addr_out;
    logic [7:0]       rd_data_in;
    logic             tx_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output start_in, base_in, len_in, rd_data_in,
        input  rd_addr_out, tx_out, busy_out, done_out
    );

    modport slave (
        input  start_in, base_in, len_in, rd_data_in,
        output rd_addr_out, tx_out, busy_out, done_out
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_baud_tick : one-cycle tick every CLKS_PER_BIT clocks, clearable|
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module uart_baud_tick
    import ulm_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_default_clks_per_bit
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    output logic tick_out
);
    localparam int             c_cnt_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    always_comb begin
        tick_out = !clear_in && (cnt_q == c_last);
        if (clear_in || tick_out) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_uart_tx : streams a block of BRAM bytes out as 8N1 UART frames |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module bram_uart_tx
    import ulm_uart_pkg::*;
#(
    parameter int ADDRW        = 9,
    parameter int CLKS_PER_BIT = c_default_clks_per_bit
) (
    input  logic          clk_in,
    input  logic          rst_in,
    bram_uart_tx_if.slave bus
);
    uart_state_t      state_q,   state_d;
    logic [ADDRW-1:0] addr_q,    addr_d;
    logic [ADDRW:0]   rem_q,     rem_d;
    logic [7:0]       shift_q,   shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             load_q,    load_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             baud_clear;
    logic             baud_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (baud_clear),
        .tick_out (baud_tick)
    );

    // The BRAM read is combinational on addr_q, so the byte is captured on
    // the first START cycle (load_q) once the new address has settled.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        load_d     = 1'b0;
        baud_clear = 1'b0;

        case (state_q)
            c_st_idle, c_st_finish: begin
                baud_clear = 1'b1;
                state_d    = c_st_idle;
                if (bus.start_in) begin
                    if (bus.len_in != '0) begin
                        addr_d    = bus.base_in;
                        rem_d     = bus.len_in;
                        bit_cnt_d = '0;
                        load_d    = 1'b1;
                        state_d   = c_st_start;
                    end else begin
                        state_d   = c_st_finish;
                    end
                end
            end
            c_st_start: begin
                if (load_q) begin
                    shift_d = bus.rd_data_in;
                end
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = c_st_data;
                end
            end
            c_st_data: begin
                if (baud_tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = c_st_stop;
                    end
                end
            end
            c_st_stop: begin
                if (baud_tick) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (ADDRW+1)'(1)) begin
                        state_d = c_st_finish;
                    end else begin
                        load_d  = 1'b1;
                        state_d = c_st_start;
                    end
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Line and status are registered, so they trail the FSM by one cycle.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = is_frame_state(state_q);
        done_d = (state_q == c_st_finish);
        if (state_q == c_st_start) begin
            tx_d = 1'b0;
        end else if (state_q == c_st_data) begin
            tx_d = shift_q[0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= c_st_idle;
            addr_q    <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            load_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            load_q    <= load_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rd_addr_out = addr_q;
    assign bus.tx_out      = tx_q;
    assign bus.busy_out    = busy_q;
    assign bus.done_out    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bram_uart_tx : directed self-checking bench, CLKS_PER_BIT = 4    |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_bram_uart_tx;
    localparam int ADDRW = 9;
    localparam int CPB   = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] mem      [0:511];
    logic       tx_hist  [0:199];
    logic       busy_hist[0:199];
    logic       done_hist[0:199];
    logic [8:0] addr_hist[0:199];

    bram_uart_tx_if #(.ADDRW(ADDRW)) bus ();

    bram_uart_tx #(
        .ADDRW        (ADDRW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    assign bus.rd_data_in = mem[bus.rd_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample k=0..n at negedges (k=0 is just after the acceptance edge);
    // start_in is driven high for k in [lo,hi], affecting the following edge.
    task automatic capture(input int n, input int lo, input int hi);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            tx_hist[k]   = bus.tx_out;
            busy_hist[k] = bus.busy_out;
            done_hist[k] = bus.done_out;
            addr_hist[k] = bus.rd_addr_out;
            bus.start_in = (k >= lo) && (k <= hi);
        end
    endtask

    function automatic logic [7:0] get_byte(input int s);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = tx_hist[s + 4*(j+1) + 2];
        return b;
    endfunction

    function automatic int count_done(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (done_hist[k]) c++;
        return c;
    endfunction

    task automatic launch(input logic [8:0] base, input logic [9:0] len);
        bus.base_in  = base;
        bus.len_in   = len;
        bus.start_in = 1'b1;
    endtask

    int t1_pat [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int bad;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        rst          = 1'b1;
        bus.start_in = 1'b0;
        bus.base_in  = '0;
        bus.len_in   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx",      32'(bus.tx_out),      32'h1);
        check("rst_busy",    32'(bus.busy_out),    32'h0);
        check("rst_done",    32'(bus.done_out),    32'h0);
        check("rst_addr",    32'(bus.rd_addr_out), 32'h0);
        check("rst_rem",     32'(dut.rem_q),       32'h0);
        check("rst_bitcnt",  32'(dut.bit_cnt_q),   32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0x55, cycle-exact waveform
        mem[0] = 8'h55;
        launch(9'd0, 10'd1);
        capture(42, -1, -1);
        check("t1_tx_k0", 32'(tx_hist[0]), 32'h1);
        bad = 0;
        for (int k = 1; k <= 40; k++) if (tx_hist[k] !== 1'(t1_pat[(k-1)/4])) bad++;
        check("t1_wave_errs", 32'(bad), 32'h0);
        check("t1_busy_k1",  32'(busy_hist[1]),  32'h1);
        check("t1_busy_k40", 32'(busy_hist[40]), 32'h1);
        check("t1_done_k40", 32'(done_hist[40]), 32'h0);
        check("t1_done_k41", 32'(done_hist[41]), 32'h1);
        check("t1_busy_k41", 32'(busy_hist[41]), 32'h0);
        check("t1_done_k42", 32'(done_hist[42]), 32'h0);
        check("t1_tx_k41",   32'(tx_hist[41]),   32'h1);

        // Zero length: done one cycle later, line untouched
        launch(9'd3, 10'd0);
        capture(3, -1, -1);
        check("t2_done_k0", 32'(done_hist[0]), 32'h0);
        check("t2_done_k1", 32'(done_hist[1]), 32'h1);
        check("t2_done_k2", 32'(done_hist[2]), 32'h0);
        check("t2_busy_any", 32'(busy_hist[0] | busy_hist[1] | busy_hist[2] | busy_hist[3]), 32'h0);
        check("t2_tx_all",   32'(tx_hist[0] & tx_hist[1] & tx_hist[2] & tx_hist[3]), 32'h1);

        // Address wrap 511 -> 0, back-to-back frames
        mem[511] = 8'hA5;
        mem[0]   = 8'h3C;
        launch(9'd511, 10'd2);
        capture(82, -1, -1);
        check("t3_addr_k0",  32'(addr_hist[0]),  32'd511);
        check("t3_addr_k20", 32'(addr_hist[20]), 32'd511);
        check("t3_addr_k60", 32'(addr_hist[60]), 32'd0);
        check("t3_byte0",    32'(get_byte(1)),   32'hA5);
        check("t3_stop0",    32'(tx_hist[39]),   32'h1);
        check("t3_start1",   32'(tx_hist[43]),   32'h0);
        check("t3_byte1",    32'(get_byte(41)),  32'h3C);
        check("t3_done_mid", 32'(count_done(1, 80)), 32'h0);
        check("t3_done_k81", 32'(done_hist[81]), 32'h1);

        // start_in pulsed mid-frame is ignored
        mem[5] = 8'hC3;
        launch(9'd5, 10'd1);
        capture(50, 15, 16);
        check("t4_byte",     32'(get_byte(1)),      32'hC3);
        check("t4_done_cnt", 32'(count_done(0, 50)), 32'h1);
        check("t4_done_k41", 32'(done_hist[41]),    32'h1);
        check("t4_busy_k45", 32'(busy_hist[45]),    32'h0);
        check("t4_tx_k48",   32'(tx_hist[48]),      32'h1);

        // start_in held through FINISH restarts immediately
        mem[7] = 8'h96;
        launch(9'd7, 10'd1);
        capture(90, 0, 40);
        check("t5_byte0",    32'(get_byte(1)),       32'h96);
        check("t5_done_k41", 32'(done_hist[41]),     32'h1);
        check("t5_busy_k41", 32'(busy_hist[41]),     32'h0);
        check("t5_done_gap", 32'(count_done(1, 81)), 32'h1);
        check("t5_busy_k42", 32'(busy_hist[42]),     32'h1);
        check("t5_tx_k42",   32'(tx_hist[42]),       32'h0);
        check("t5_byte1",    32'(get_byte(42)),      32'h96);
        check("t5_done_k82", 32'(done_hist[82]),     32'h1);

        // Reset during data bit 3 aborts at once
        mem[9] = 8'h00;
        launch(9'd9, 10'd1);
        capture(18, -1, -1);
        check("t6_tx_bit3",  32'(tx_hist[18]),   32'h0);
        check("t6_busy_pre", 32'(busy_hist[18]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_tx_rst",   32'(bus.tx_out),      32'h1);
        check("t6_busy_rst", 32'(bus.busy_out),    32'h0);
        check("t6_addr_rst", 32'(bus.rd_addr_out), 32'h0);
        check("t6_rem_rst",  32'(dut.rem_q),       32'h0);
        @(negedge clk);
        rst = 1'b0;
        capture(50, -1, -1);
        check("t6_no_done", 32'(count_done(0, 50)), 32'h0);
        bad = 0;
        for (int k = 0; k <= 50; k++) if (tx_hist[k] !== 1'b1) bad++;
        check("t6_tx_idle", 32'(bad), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_uart_tx.md
BRAM_UART_TX -- requirements
Module: bram_uart_tx

Interface
REQ-001 The block SHALL have parameter ADDRW, default 9, giving the byte-address width of the source dual-port BRAM (512 x 8).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 104, giving clock cycles per UART bit (must be >= 2).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk_in  input  1  is the sole clock; all state updates on its rising edge.
REQ-005 Port rst_in  input  1  is the asynchronous active-high reset.
REQ-006 Port start_in  input  1  is the request to transmit a block; it is sampled only while idle.
REQ-007 Port base_in  input  ADDRW  is the first BRAM byte address of the block.
REQ-008 Port len_in  input  ADDRW+1  is the byte count, 0..512.
REQ-009 Port rd_addr_out  output  ADDRW  drives the BRAM read-address port.
REQ-010 Port rd_data_in  input  8  is the combinational BRAM read data for rd_addr_out.
REQ-011 Port tx_out  output  1  is the UART serial line, 8N1, idle high.
REQ-012 Port busy_out  output  1  is high from acceptance until the last stop bit ends.
REQ-013 Port done_out  output  1  is a one-cycle pulse marking completion.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, FINISH.
REQ-015 In IDLE with start_in=1 and len_in>0, the block SHALL latch base_in into an address register and len_in into a remaining counter, then enter START on the next edge.
REQ-016 In IDLE with start_in=1 and len_in=0, the block SHALL enter FINISH without toggling tx_out.
REQ-017 On entry to START, the block SHALL capture rd_data_in into an 8-bit shift register and drive tx_out=0 for exactly CLKS_PER_BIT cycles.
REQ-018 In DATA, the block SHALL shift out 8 bits LSB first, each held exactly CLKS_PER_BIT cycles.
REQ-019 In STOP, the block SHALL drive tx_out=1 for CLKS_PER_BIT cycles, then increment the address modulo 2^ADDRW and decrement remaining.
REQ-020 At the end of STOP, the block SHALL enter START if remaining is nonzero, else FINISH, with no idle gap between frames.
REQ-021 FINISH SHALL last one cycle, assert done_out=1 and busy_out=0, then return to IDLE.
REQ-022 start_in SHALL be ignored in every state except IDLE and FINISH; start_in during FINISH is accepted as if in IDLE.
REQ-023 Address wrap SHALL be silent: base 511, length 2 reads 511 then 0.
REQ-024 rd_addr_out SHALL equal the address register at all times; it is stable for the whole frame.
REQ-025 The first falling edge on tx_out SHALL occur one cycle after the acceptance edge.
REQ-026 Total busy time for N bytes SHALL be exactly N*10*CLKS_PER_BIT cycles, followed by one FINISH cycle.

Reset
REQ-027 While rst_in=1, the FSM SHALL be in IDLE.
REQ-028 While rst_in=1, outputs SHALL be tx_out=1, busy_out=0, done_out=0, and rd_addr_out=0.
REQ-029 While rst_in=1, the bit counter, baud counter and remaining counter SHALL be 0.
REQ-030 Reset mid-frame SHALL abort immediately, return tx_out high, and produce no done_out pulse.

Structure
REQ-031 Package ulm_uart_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT constant.
REQ-032 The baud counter SHALL be a sub-module, uart_baud_tick, emitting a one-cycle tick every CLKS_PER_BIT cycles, restartable by a clear input.

Verification (CLKS_PER_BIT=4 in bench)
REQ-033 The bench SHALL cover: BRAM[0]=0x55, base 0, len 1 -> tx_out 0,1,0,1,0,1,0,1,0,1 each 4 cycles, then done_out pulse at cycle 41.
REQ-034 The bench SHALL cover: len 0 -> done_out one cycle after start, tx_out constant 1, busy_out never high.
REQ-035 The bench SHALL cover: base 511, len 2, BRAM[511]=0xA5, BRAM[0]=0x3C -> bytes A5 then 3C decoded back-to-back, rd_addr_out 511 then 0.
REQ-036 The bench SHALL cover: start_in pulsed mid-frame -> ignored, with a single done_out after the original length.
REQ-037 The bench SHALL cover: start_in held high through FINISH with len 1 -> second frame starts, and there is exactly one done_out cycle between frames.
REQ-038 The bench SHALL cover: rst_in asserted during DATA bit 3 -> tx_out=1 and busy_out=0 within the same cycle, and no done_out.
